// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-back control slice.
package rf_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 3;

  // Write-back source identity; also the round-robin "last granted" pointer.
  typedef enum logic {WB_ALU = 1'b0, WB_MEM = 1'b1} wb_src_t;

endpackage

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-requester round-robin arbiter. req[0]=ALU, req[1]=MEM.
// On a tie the requester that was not granted last wins.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output wb_src_t    last
);

  wb_src_t r_last;

  // Combinational grant: single requester wins outright, ties alternate.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last == WB_ALU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer moves only when something is actually granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= WB_ALU;
    end else if (gnt != 2'b00) begin
      r_last <= gnt[1] ? WB_MEM : WB_ALU;
    end
  end

  assign last = r_last;

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler / hazard controller for a 1W/2R sync-read register file.
// Arbitrates ALU and MEM results onto the write port, tracks pending
// destinations, stalls reads of in-flight registers and forwards data for
// same-address read-during-write.
module rf_wb_sched
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_dst,
  output logic                  iss_ready,
  input  logic                  alu_wb_valid,
  input  logic [ADDR_WIDTH-1:0] alu_wb_sel,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  mem_wb_valid,
  input  logic [ADDR_WIDTH-1:0] mem_wb_sel,
  input  logic [DATA_WIDTH-1:0] mem_wb_data,
  output logic                  mem_wb_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_sel,
  output logic [DATA_WIDTH-1:0] wr_port,
  input  logic                  rd_a_en,
  input  logic [ADDR_WIDTH-1:0] rd_a_sel,
  input  logic                  rd_b_en,
  input  logic [ADDR_WIDTH-1:0] rd_b_sel,
  output logic                  stall_a,
  output logic                  stall_b,
  output logic                  fwd_a_en,
  output logic [DATA_WIDTH-1:0] fwd_a_data,
  output logic                  fwd_b_en,
  output logic [DATA_WIDTH-1:0] fwd_b_data
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  wb_src_t               w_last;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_gnt_sel;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_iss_fire;

  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_sel;
  logic [DATA_WIDTH-1:0] r_wr_port;
  logic [NUM_REGS-1:0]   r_pend;
  logic                  r_fwd_a_en;
  logic                  r_fwd_b_en;
  logic [DATA_WIDTH-1:0] r_fwd_a_data;
  logic [DATA_WIDTH-1:0] r_fwd_b_data;

  // Requests are masked during reset so an in-flight handshake is dropped.
  assign w_req = reset ? 2'b00 : {mem_wb_valid, alu_wb_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (w_req),
    .gnt   (w_gnt),
    .last  (w_last)
  );

  assign alu_wb_ready = w_gnt[0];
  assign mem_wb_ready = w_gnt[1];
  assign w_xfer       = |w_gnt;
  assign w_gnt_sel    = w_gnt[1] ? mem_wb_sel  : alu_wb_sel;
  assign w_gnt_data   = w_gnt[1] ? mem_wb_data : alu_wb_data;

  // A write retiring this cycle frees its destination for reuse immediately.
  assign iss_ready  = !r_pend[iss_dst] || (r_wr_en && (r_wr_sel == iss_dst));
  assign w_iss_fire = iss_valid && iss_ready;

  // Operand is unavailable while pending, unless its write lands this cycle.
  assign stall_a = rd_a_en && r_pend[rd_a_sel] && !(r_wr_en && (r_wr_sel == rd_a_sel));
  assign stall_b = rd_b_en && r_pend[rd_b_sel] && !(r_wr_en && (r_wr_sel == rd_b_sel));

  // Write-port register: one cycle after transfer; sel/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_port <= '0;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_wr_sel  <= w_gnt_sel;
        r_wr_port <= w_gnt_data;
      end
    end
  end

  // Scoreboard: clear on retiring write, then set on allocation so set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_iss_fire && (iss_dst == ADDR_WIDTH'(i))) begin
          r_pend[i] <= 1'b1;
        end else if (r_wr_en && (r_wr_sel == ADDR_WIDTH'(i))) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Forwarding: the RF returns stale data on same-address read-during-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_a_en   <= 1'b0;
      r_fwd_b_en   <= 1'b0;
      r_fwd_a_data <= '0;
      r_fwd_b_data <= '0;
    end else begin
      r_fwd_a_en <= rd_a_en && r_wr_en && (r_wr_sel == rd_a_sel);
      r_fwd_b_en <= rd_b_en && r_wr_en && (r_wr_sel == rd_b_sel);
      if (rd_a_en && r_wr_en && (r_wr_sel == rd_a_sel)) r_fwd_a_data <= r_wr_port;
      if (rd_b_en && r_wr_en && (r_wr_sel == rd_b_sel)) r_fwd_b_data <= r_wr_port;
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_sel     = r_wr_sel;
  assign wr_port    = r_wr_port;
  assign fwd_a_en   = r_fwd_a_en;
  assign fwd_b_en   = r_fwd_b_en;
  assign fwd_a_data = r_fwd_a_data;
  assign fwd_b_data = r_fwd_b_data;

endmodule
